// File: rtl/onehot_deco_unit.sv
// onehot_deco_unit: independent 2-to-4 and 3-to-8 one-hot decoders with
// combinational outputs and one-cycle registered copies.
// Optional macro DECO_CASCADE_EN adds a 5-to-32 cascade decode
// (out32/out32_q) built from the 2-to-4 decoder driving four 3-to-8 stages.
module onehot_deco_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        en2,
    input  logic [1:0]  in2,
    output logic [3:0]  out4,
    output logic [3:0]  out4_q,
    input  logic        en3,
    input  logic [2:0]  in3,
    output logic [7:0]  out8,
    output logic [7:0]  out8_q
`ifdef DECO_CASCADE_EN
    ,
    output logic [31:0] out32,
    output logic [31:0] out32_q
`endif
);

    localparam int unsigned W4  = 4;
    localparam int unsigned W8  = 8;
`ifdef DECO_CASCADE_EN
    localparam int unsigned W32 = 32;
`endif

    logic [W4-1:0] out4_d;
    logic [W8-1:0] out8_d;

    // 2-to-4 decode: bit index equals in2, gated by en2
    always_comb begin
        out4 = '0;
        for (int k = 0; k < int'(W4); k++) begin
            out4[k] = en2 && (in2 == 2'(k));
        end
    end

    // 3-to-8 decode: bit index equals in3, gated by en3
    always_comb begin
        out8 = '0;
        for (int k = 0; k < int'(W8); k++) begin
            out8[k] = en3 && (in3 == 3'(k));
        end
    end

`ifdef DECO_CASCADE_EN
    logic [W8-1:0]  sel8;
    logic [W32-1:0] out32_d;

    // Ungated in3 decode shared by the four cascade stages; en3 plays no part
    always_comb begin
        sel8 = '0;
        for (int j = 0; j < int'(W8); j++) begin
            sel8[j] = (in3 == 3'(j));
        end
    end

    // Cascade: out4[k] enables the 3-to-8 stage feeding out32[8k+7:8k]
    always_comb begin
        out32 = '0;
        for (int k = 0; k < int'(W4); k++) begin
            out32[8*k +: 8] = out4[k] ? sel8 : 8'h00;
        end
    end
`endif

    // Next values for the registered copies track the live decode
    always_comb begin
        out4_d = out4;
        out8_d = out8;
`ifdef DECO_CASCADE_EN
        out32_d = out32;
`endif
    end

    // Registered copies: cleared on a reset edge, otherwise reload every cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            out4_q  <= '0;
            out8_q  <= '0;
`ifdef DECO_CASCADE_EN
            out32_q <= '0;
`endif
        end else begin
            out4_q  <= out4_d;
            out8_q  <= out8_d;
`ifdef DECO_CASCADE_EN
            out32_q <= out32_d;
`endif
        end
    end

endmodule

// File: tb/tb_onehot_deco_unit.sv
// tb_onehot_deco_unit: directed and randomized checks of onehot_deco_unit
// against a shift-based reference model. Define DECO_CASCADE_EN to also
// cover the 5-to-32 cascade outputs.
module tb_onehot_deco_unit;

    logic        clk;
    logic        reset;
    logic        en2;
    logic [1:0]  in2;
    logic [3:0]  out4;
    logic [3:0]  out4_q;
    logic        en3;
    logic [2:0]  in3;
    logic [7:0]  out8;
    logic [7:0]  out8_q;
`ifdef DECO_CASCADE_EN
    logic [31:0] out32;
    logic [31:0] out32_q;
`endif

    int unsigned n_checks;
    int unsigned n_fail;

    // model state for the registered outputs
    logic [3:0]  m4_q;
    logic [7:0]  m8_q;
    logic [31:0] m32_q;

    onehot_deco_unit dut (
        .clk    (clk),
        .reset  (reset),
        .en2    (en2),
        .in2    (in2),
        .out4   (out4),
        .out4_q (out4_q),
        .en3    (en3),
        .in3    (in3),
        .out8   (out8),
        .out8_q (out8_q)
`ifdef DECO_CASCADE_EN
        ,
        .out32  (out32),
        .out32_q(out32_q)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model4(input logic e, input logic [1:0] s);
        return e ? 4'(4'd1 << s) : 4'h0;
    endfunction

    function automatic logic [7:0] model8(input logic e, input logic [2:0] s);
        return e ? 8'(8'd1 << s) : 8'h00;
    endfunction

    function automatic logic [31:0] model32(input logic e, input logic [1:0] hi, input logic [2:0] lo);
        int unsigned idx;
        idx = 32'(hi) * 8 + 32'(lo);
        return e ? 32'(32'd1 << idx) : 32'h0;
    endfunction

    // Drive one cycle of stimulus at the negedge, check live and held outputs,
    // then check the registered copies just after the rising edge.
    task automatic apply(input logic r, input logic e2, input logic [1:0] s2,
                         input logic e3, input logic [2:0] s3);
        @(negedge clk);
        reset = r;
        en2   = e2;
        in2   = s2;
        en3   = e3;
        in3   = s3;
        #1;
        check_eq("out4", 32'(out4), 32'(model4(e2, s2)));
        check_eq("out8", 32'(out8), 32'(model8(e3, s3)));
        check_eq("out4_q_hold", 32'(out4_q), 32'(m4_q));
        check_eq("out8_q_hold", 32'(out8_q), 32'(m8_q));
`ifdef DECO_CASCADE_EN
        check_eq("out32", out32, model32(e2, s2, s3));
        check_eq("out32_q_hold", out32_q, m32_q);
`endif
        m4_q  = r ? 4'h0  : model4(e2, s2);
        m8_q  = r ? 8'h00 : model8(e3, s3);
        m32_q = r ? 32'h0 : model32(e2, s2, s3);
        @(posedge clk);
        #1;
        check_eq("out4_q", 32'(out4_q), 32'(m4_q));
        check_eq("out8_q", 32'(out8_q), 32'(m8_q));
`ifdef DECO_CASCADE_EN
        check_eq("out32_q", out32_q, m32_q);
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        en2 = 1'b0; in2 = 2'd0; en3 = 1'b0; in3 = 3'd0;
        m4_q = 4'h0; m8_q = 8'h00; m32_q = 32'h0;

        // reset state
        @(posedge clk);
        #1;
        check_eq("rst_out4_q", 32'(out4_q), 32'h0);
        check_eq("rst_out8_q", 32'(out8_q), 32'h0);
`ifdef DECO_CASCADE_EN
        check_eq("rst_out32_q", out32_q, 32'h0);
`endif

        // both enables low: every select decodes to zero
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 8; b++)
                apply(1'b0, 1'b0, 2'(a), 1'b0, 3'(b));

        // enabled sweeps, covering the cascade map with en3 both ways
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 8; b++)
                apply(1'b0, 1'b1, 2'(a), 1'(b & 1), 3'(b));

        // fixed points
        apply(1'b0, 1'b1, 2'd2, 1'b1, 3'd5);
        check_eq("in3_5_out8", 32'(out8), 32'h20);
`ifdef DECO_CASCADE_EN
        check_eq("cascade_2_5", out32, 32'h0020_0000);
`endif
        apply(1'b0, 1'b1, 2'd0, 1'b1, 3'd6);
        check_eq("in3_6_out8", 32'(out8), 32'h40);

        // reset edge with live decode, then release
        apply(1'b1, 1'b1, 2'd3, 1'b1, 3'd7);
        check_eq("rst_edge_out8_q", 32'(out8_q), 32'h00);
        apply(1'b0, 1'b1, 2'd3, 1'b1, 3'd7);
        check_eq("rel_out8_q", 32'(out8_q), 32'h80);

        // in2 1 -> 2: registered copy lags by one edge
        apply(1'b0, 1'b1, 2'd1, 1'b0, 3'd0);
        apply(1'b0, 1'b1, 2'd2, 1'b0, 3'd0);
        check_eq("lag_out4_q", 32'(out4_q), 32'h4);

        // randomized traffic with occasional mid-stream resets
        for (int i = 0; i < 400; i++)
            apply(($urandom_range(0, 9) == 0), 1'($urandom), 2'($urandom),
                  1'($urandom), 3'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/onehot_deco_unit.md
Name: onehot_deco_unit

Overview:
- Dual one-hot decoder block: a 2-to-4 decoder and a 3-to-8 decoder, each with its own enable.
- Primitive address/select decode element for register-file write-select and similar one-hot selection.
- Outputs are provided both combinationally and as registered copies.
- An optional cascade stage combines both decoders into a 5-to-32 decode.

Parameters:
None (widths fixed: 2→4 and 3→8).

Ports:
clk  input  1  system clock; all registered outputs update on its rising edge
reset  input  1  synchronous, active-high reset
en2  input  1  enable for 2-to-4 decoder
in2  input  2  select for 2-to-4 decoder; in2[1] is MSB
out4  output  4  combinational one-hot 2-to-4 result
out4_q  output  4  registered copy of out4
en3  input  1  enable for 3-to-8 decoder
in3  input  3  select for 3-to-8 decoder; in3[2] is MSB
out8  output  8  combinational one-hot 3-to-8 result
out8_q  output  8  registered copy of out8
out32  output  32  (DECO_CASCADE_EN only) combinational 5-to-32 result
out32_q  output  32  (DECO_CASCADE_EN only) registered copy of out32

Behaviour:
- One clock; reset is synchronous and active-high.
- Port names clk and reset.
- Combinational decode, zero latency:
  - out4[k] = en2 AND (in2 == k), k = 0..3.
  - out8[k] = en3 AND (in3 == k), k = 0..7.
- Output bit index equals the unsigned input value, e.g. in3=3'b101 → out8=8'b0010_0000.
- Enable low → output all zeros regardless of select.
- Enable high → exactly one bit set (one-hot); never more than one bit set.
- No X propagation on known inputs; all select values are legal, no wrap or invalid codes.
- Registered outputs:
  - On each rising clk with reset=1: out4_q=4'h0, out8_q=8'h00 (and out32_q=32'h0 when compiled).
  - On each rising clk with reset=0: out4_q←out4, out8_q←out8 (out32_q←out32).
  - Latency exactly one cycle; no hold/stall input; registers update every cycle.
- Reset does not affect combinational outputs; they always reflect current inputs.
- Reset mid-operation clears the registered outputs on that edge only; next edge with reset=0 reloads the current decode.
- The two decoders are fully independent; simultaneous changes on both affect only their own outputs.

Optional Feature:
- Macro: DECO_CASCADE_EN.
- Defined:
  - Adds out32/out32_q, built as a cascade: the 2-to-4 decoder (in2, en2) drives the enables of four 3-to-8 decoders, all selected by in3.
  - out32[{in2,in3}] = en2 AND en3 is NOT used; the cascade enable is en2 only, so out32[i] = en2 AND ({in2,in3} == i).
  - out32[7:0] corresponds to in2=0, up through out32[31:24] for in2=3.
  - out32_q registered like the other registered outputs, reset to 0.
- Undefined: out32/out32_q ports and logic absent; remaining behaviour identical.

Test Plan:
- en2=0, en3=0, sweep in2 0..3 and in3 0..7 → out4=0, out8=0 at every step.
- en2=1, sweep in2 0..3 → out4 = 0001, 0010, 0100, 1000; en3=1, in3=6 → out8=8'h40.
- reset=1 for one edge with en3=1, in3=7 → out8_q=8'h00; release reset → out8_q=8'h80 one cycle later.
- in2 changes 1→2 between edges with en2=1 → out4 changes immediately; out4_q=4'b0010 until the next edge, then 4'b0100.
- Assert reset mid-sweep for one cycle → registered outputs 0 on that edge only; combinational outputs unaffected.
- DECO_CASCADE_EN: en2=0, sweep {in2,in3} 0..31 → out32=0; en2=1, same sweep → out32 = 1<<i for each i, e.g. in2=2, in3=5 → out32=32'h0020_0000; out32_q matches one cycle later.
